// File: rtl/display_pkg.sv
// Shared definitions for the display scan path.
//   NUM_DIGITS, BCD_W, MAX_DISPLAY : display geometry and saturation limit
//   state_e                        : bin2bcd_seq FSM states
//   DIGIT_EN_OFF                   : active-low enable pattern with every digit dark
//   bcd_add3()                     : double-dabble correction step (+3 on nibbles >= 5)
package display_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned BCD_W       = 16;
    localparam int unsigned MAX_DISPLAY = 9999;

    localparam logic [NUM_DIGITS-1:0] DIGIT_EN_OFF = 4'b1111;

    typedef enum logic {
        IDLE,
        CONV
    } state_e;

    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to 4-digit BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_value    : binary input, saturated to MAX_DISPLAY on capture
//   i_valid    : single-cycle load strobe, ignored while busy
//   o_busy     : high for exactly BIN_W cycles per conversion
//   o_bcd      : display BCD, updated atomically when a conversion ends
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] i_value,
    input  logic             i_valid,
    output logic             o_busy,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e           r_state, w_state_next;
    logic [BIN_W-1:0] r_shift, w_shift_next;
    logic [BCD_W-1:0] r_work, w_work_next;
    logic [BCD_W-1:0] r_disp, w_disp_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] w_work_shifted;
    logic [BIN_W-1:0] w_sat;

    assign w_sat          = (32'(i_value) > MAX_DISPLAY) ? BIN_W'(MAX_DISPLAY) : i_value;
    assign w_adj          = bcd_add3(r_work);
    assign w_work_shifted = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_work  <= '0;
            r_disp  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_work  <= w_work_next;
            r_disp  <= w_disp_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_work_next  = r_work;
        w_disp_next  = r_disp;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_shift_next = w_sat;
                    w_work_next  = '0;
                    w_cnt_next   = '0;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                w_work_next  = w_work_shifted;
                w_shift_next = r_shift << 1;
                w_cnt_next   = r_cnt + CNT_W'(1);
                // The final iteration's result goes straight to the display so busy
                // stays high for exactly BIN_W cycles.
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_disp_next  = w_work_shifted;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy = (r_state == CONV);
    assign o_bcd  = r_disp;

endmodule

// File: rtl/display_scan_driver.sv
// Binary-to-BCD conversion plus 4-digit time-multiplexed scan for the 7-segment path.
//   clk, rst_n  : clock, asynchronous active-low reset
//   value_in    : binary amount to display (saturates at 9999)
//   value_valid : single-cycle load strobe, ignored while busy
//   blank_lz    : 1 = suppress leading zeros
//   busy        : conversion in progress
//   digit_code  : BCD digit of the active slot (registered)
//   digit_en_n  : active-low digit enables, bit 0 = least significant (registered)
module display_scan_driver
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BIN_W    = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value_in,
    input  logic             value_valid,
    input  logic             blank_lz,
    output logic             busy,
    output logic [3:0]       digit_code,
    output logic [3:0]       digit_en_n
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    logic [BCD_W-1:0] w_bcd;
    logic [PRE_W-1:0] r_presc;
    logic [1:0]       r_idx;
    logic [3:0]       r_digit_code;
    logic [3:0]       r_digit_en_n;
    logic             w_terminal;
    logic             w_upper_zero;
    logic             w_blank;
    logic [3:0]       w_digit;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_value (value_in),
        .i_valid (value_valid),
        .o_busy  (busy),
        .o_bcd   (w_bcd)
    );

    assign w_terminal = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_digit    = w_bcd[{r_idx, 2'b00} +: 4];

    // A slot is dark only if it and every more significant digit are zero.
    always_comb begin
        w_upper_zero = 1'b0;
        unique case (r_idx)
            2'd0: w_upper_zero = 1'b0;
            2'd1: w_upper_zero = (w_bcd[15:4] == '0);
            2'd2: w_upper_zero = (w_bcd[15:8] == '0);
            2'd3: w_upper_zero = (w_bcd[15:12] == '0);
            default: w_upper_zero = 1'b0;
        endcase
    end

    assign w_blank = blank_lz & w_upper_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_digit_code <= '0;
            r_digit_en_n <= DIGIT_EN_OFF;
        end else begin
            r_presc      <= w_terminal ? '0 : r_presc + PRE_W'(1);
            r_idx        <= w_terminal ? r_idx + 2'd1 : r_idx;
            r_digit_code <= w_digit;
            r_digit_en_n <= w_blank ? DIGIT_EN_OFF : ~(4'b0001 << r_idx);
        end
    end

    assign digit_code = r_digit_code;
    assign digit_en_n = r_digit_en_n;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed self-checking bench for display_scan_driver with SCAN_DIV=4.
module tb_display_scan_driver;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned BIN_W    = 14;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] value_in;
    logic             value_valid;
    logic             blank_lz;
    logic             busy;
    logic [3:0]       digit_code;
    logic [3:0]       digit_en_n;

    int n_vec;
    int n_err;

    display_scan_driver #(
        .SCAN_DIV (SCAN_DIV),
        .BIN_W    (BIN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .blank_lz    (blank_lz),
        .busy        (busy),
        .digit_code  (digit_code),
        .digit_en_n  (digit_en_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for the first cycle of slot 0, i.e. digit_en_n turning 1110.
    task automatic sync_slot0(output bit found);
        logic [3:0] prev;
        found = 1'b0;
        prev  = digit_en_n;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (digit_en_n == 4'b1110 && prev != 4'b1110) begin
                found = 1'b1;
                break;
            end
            prev = digit_en_n;
        end
    endtask

    // Loads a value and returns the number of cycles busy was seen high.
    task automatic load_value(input int v, output int cycles);
        value_in    = BIN_W'(v);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        value_in    = '0;
        value_valid = 1'b0;
        blank_lz    = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (digit_en_n !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_en: got %b want 1111", digit_en_n);
        end
        n_vec++;
        if (digit_code !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_code_busy: got code=%0d busy=%b want 0/0", digit_code, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (digit_en_n !== 4'b1110 || digit_code !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got en=%b code=%0d busy=%b want 1110/0/0",
                     digit_en_n, digit_code, busy);
        end
    endtask

    task automatic test_convert_1234;
        int  cycles;
        bit  found;
        logic [3:0] exp_code [4];
        logic [3:0] exp_en   [4];
        exp_code[0] = 4'd4; exp_en[0] = 4'b1110;
        exp_code[1] = 4'd3; exp_en[1] = 4'b1101;
        exp_code[2] = 4'd2; exp_en[2] = 4'b1011;
        exp_code[3] = 4'd1; exp_en[3] = 4'b0111;
        blank_lz = 1'b0;
        load_value(1234, cycles);
        n_vec++;
        if (cycles != 14) begin
            n_err++;
            $display("FAIL busy_len_1234: got %0d cycles want 14", cycles);
        end
        sync_slot0(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_1234: got no slot0 start want one within 40 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (digit_code !== exp_code[i/4] || digit_en_n !== exp_en[i/4]) begin
                n_err++;
                $display("FAIL scan_1234 cyc%0d: got code=%0d en=%b want %0d/%b",
                         i, digit_code, digit_en_n, exp_code[i/4], exp_en[i/4]);
            end
        end
    endtask

    task automatic test_blank_40;
        int  cycles;
        bit  found;
        logic [3:0] exp_code [4];
        logic [3:0] exp_en   [4];
        exp_code[0] = 4'd0; exp_en[0] = 4'b1110;
        exp_code[1] = 4'd4; exp_en[1] = 4'b1101;
        exp_code[2] = 4'd0; exp_en[2] = 4'b1111;
        exp_code[3] = 4'd0; exp_en[3] = 4'b1111;
        blank_lz = 1'b1;
        load_value(40, cycles);
        sync_slot0(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_40_blank: got no slot0 start want one within 40 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (digit_code !== exp_code[i/4] || digit_en_n !== exp_en[i/4]) begin
                n_err++;
                $display("FAIL scan_40_blank cyc%0d: got code=%0d en=%b want %0d/%b",
                         i, digit_code, digit_en_n, exp_code[i/4], exp_en[i/4]);
            end
        end
        blank_lz = 1'b0;
        exp_en[2] = 4'b1011;
        exp_en[3] = 4'b0111;
        sync_slot0(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_40_noblank: got no slot0 start want one within 40 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (digit_code !== exp_code[i/4] || digit_en_n !== exp_en[i/4]) begin
                n_err++;
                $display("FAIL scan_40_noblank cyc%0d: got code=%0d en=%b want %0d/%b",
                         i, digit_code, digit_en_n, exp_code[i/4], exp_en[i/4]);
            end
        end
    endtask

    task automatic test_saturate;
        int cycles;
        bit found;
        blank_lz    = 1'b0;
        value_in    = BIN_W'(12000);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        cycles = 0;
        // A second load while busy must be dropped without restarting the conversion.
        while (busy && cycles < 40) begin
            cycles++;
            if (cycles == 3) begin
                value_in    = BIN_W'(5);
                value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
            end
            @(negedge clk);
        end
        value_valid = 1'b0;
        n_vec++;
        if (cycles != 14) begin
            n_err++;
            $display("FAIL busy_len_sat: got %0d cycles want 14", cycles);
        end
        sync_slot0(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_sat: got no slot0 start want one within 40 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (digit_code !== 4'd9 || digit_en_n !== ~(4'b0001 << (i/4))) begin
                n_err++;
                $display("FAIL scan_sat cyc%0d: got code=%0d en=%b want 9/%b",
                         i, digit_code, digit_en_n, ~(4'b0001 << (i/4)));
            end
        end
    endtask

    task automatic test_reset_mid_conv;
        bit found;
        value_in    = BIN_W'(5678);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_before_rst: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || digit_code !== 4'd0 || digit_en_n !== 4'b1111) begin
            n_err++;
            $display("FAIL async_rst: got busy=%b code=%0d en=%b want 0/0/1111",
                     busy, digit_code, digit_en_n);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync_slot0(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_after_rst: got no slot0 start want one within 40 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (digit_code !== 4'd0 || digit_en_n !== ~(4'b0001 << (i/4)) || busy !== 1'b0) begin
                n_err++;
                $display("FAIL scan_after_rst cyc%0d: got code=%0d en=%b busy=%b want 0/%b/0",
                         i, digit_code, digit_en_n, busy, ~(4'b0001 << (i/4)));
            end
        end
    endtask

    task automatic test_atomic_update;
        int  cycles;
        bit  found;
        bit  seen_new;
        int  slot;
        logic [3:0] old_d [4];
        logic [3:0] new_d [4];
        old_d[0] = 4'd5; old_d[1] = 4'd4; old_d[2] = 4'd3; old_d[3] = 4'd2;
        new_d[0] = 4'd1; new_d[1] = 4'd0; new_d[2] = 4'd0; new_d[3] = 4'd1;
        blank_lz = 1'b0;
        load_value(2345, cycles);
        sync_slot0(found);
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_atomic: got no slot0 start want one within 40 cycles");
        end
        @(negedge clk);
        value_in    = BIN_W'(1001);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        seen_new = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            case (digit_en_n)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            n_vec++;
            if (slot < 0) begin
                n_err++;
                $display("FAIL atomic_en cyc%0d: got en=%b want one-hot low", c, digit_en_n);
            end else if (digit_code === new_d[slot]) begin
                seen_new = 1'b1;
            end else if (digit_code !== old_d[slot] || seen_new) begin
                n_err++;
                $display("FAIL atomic_digit cyc%0d slot%0d: got %0d want %0d%s",
                         c, slot, digit_code, new_d[slot], seen_new ? "" : " or old");
            end
        end
        n_vec++;
        if (!seen_new) begin
            n_err++;
            $display("FAIL atomic_switch: got no 1001 digits want switch to 1001");
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_convert_1234();
        test_blank_40();
        test_saturate();
        test_reset_mid_conv();
        test_atomic_update();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
